fmul_share_arbiter: RTL

- Shares one `fsize_multiplier` (float × signed INT_SIZE) among NUM_REQ requesters.
- Round-robin arbitration; at most one issue per cycle into the fixed-latency multiplier pipeline.
- Each issue carries a requester tag through a delay line matched to MULTIPLIER_DELAY.
- Returning products are steered into per-requester result FIFOs. Each FIFO has its own valid/ready handshake and credit-based admission, so nothing is ever dropped.

---
 rtl/sparq_pkg.sv | 17 +
 rtl/fmul_result_fifo.sv | 62 ++++++
 rtl/fmul_share_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sparq_pkg.sv
// Shared SPARQ definitions: datapath widths, multiplier latency and the requester tag type.
// Ports: none (package).
// Latency/backpressure: not applicable.
package SPARQ_PKG;

    localparam int FLOAT_SIZE       = 16;   // half-precision float operand/result
    localparam int INT_SIZE         = 4;    // signed integer multiplier operand
    localparam int MULTIPLIER_DELAY = 6;    // fsize_multiplier pipeline depth in cycles

    // Default number of requesters sharing one fsize_multiplier.
    localparam int FMUL_NUM_REQ     = 4;
    localparam int FMUL_TAG_W       = (FMUL_NUM_REQ > 1) ? $clog2(FMUL_NUM_REQ) : 1;

    // Requester index carried alongside each product through the multiplier latency.
    typedef logic [FMUL_TAG_W-1:0] fmul_tag_t;

endpackage

// File: rtl/fmul_result_fifo.sv
// Per-requester result FIFO with occupancy count; pop is ignored while empty.
// Ports: clk/rst, push + push_data, pop, head (oldest entry), count (entries held).
// Latency: a push is visible at head/count the cycle after; no internal backpressure.
module fmul_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: only entries below count are ever presented as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // The upstream credit scheme must never push into a full FIFO.
    assert property (@(posedge clk) disable iff (rst) push |-> (count != CNT_W'(DEPTH)));

endmodule

// File: rtl/fmul_share_arbiter.sv
// Round-robin share of one fixed-latency float x int multiplier among NUM_REQ requesters.
// Ports: req_* operand handshake in, mul_* to/from the multiplier, res_* per-requester results, err_sync.
// Latency LAT+2 from accept to res_valid; a requester is only granted while it holds a free result credit.
module fmul_share_arbiter
    import SPARQ_PKG::*;
#(
    parameter int NUM_REQ   = FMUL_NUM_REQ,   // must not exceed 2**FMUL_TAG_W
    parameter int RES_DEPTH = 4,
    parameter int LAT       = MULTIPLIER_DELAY
) (
    input  logic                             aclk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*FLOAT_SIZE-1:0]    req_a,
    input  logic [NUM_REQ*INT_SIZE-1:0]      req_b,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             mul_a_tvalid,
    output logic [FLOAT_SIZE-1:0]            mul_a_tdata,
    output logic                             mul_b_tvalid,
    output logic [INT_SIZE-1:0]              mul_b_tdata,
    input  logic                             mul_result_tvalid,
    input  logic [FLOAT_SIZE-1:0]            mul_result_tdata,
    output logic [NUM_REQ-1:0]               res_valid,
    output logic [NUM_REQ*FLOAT_SIZE-1:0]    res_data,
    input  logic [NUM_REQ-1:0]               res_ready,
    output logic                             err_sync
);

    localparam int CNT_W = $clog2(RES_DEPTH + 1);

    logic [CNT_W-1:0]   in_flight  [NUM_REQ];
    logic [CNT_W-1:0]   fifo_count [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] wb_hit;

    fmul_tag_t rr_ptr;
    fmul_tag_t grant_idx;
    fmul_tag_t scan_idx;
    fmul_tag_t issue_tag;
    logic      grant_vld;
    logic      issue_vld;

    logic      tag_vld  [LAT];
    fmul_tag_t tag_pipe [LAT];
    logic      wb_vld;
    fmul_tag_t wb_tag;

    // A requester holds a credit while its in-flight plus queued results leave a FIFO slot free.
    // Registered counts only, so a slot freed by a pop is reusable the following cycle.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && !rst &&
                          ((CNT_W+1)'(in_flight[i]) + (CNT_W+1)'(fifo_count[i]) < (CNT_W+1)'(RES_DEPTH));
        end
    end

    // Scan downward so the last hit, i.e. the one closest to rr_ptr, wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        req_ready = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            scan_idx = fmul_tag_t'((int'(rr_ptr) + k) % NUM_REQ);
            if (eligible[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Issue register feeding both multiplier operand channels; data holds when idle.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            issue_vld   <= 1'b0;
            issue_tag   <= '0;
            mul_a_tdata <= '0;
            mul_b_tdata <= '0;
            rr_ptr      <= '0;
        end else begin
            issue_vld <= grant_vld;
            if (grant_vld) begin
                issue_tag   <= grant_idx;
                mul_a_tdata <= req_a[int'(grant_idx)*FLOAT_SIZE +: FLOAT_SIZE];
                mul_b_tdata <= req_b[int'(grant_idx)*INT_SIZE +: INT_SIZE];
                rr_ptr      <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + fmul_tag_t'(1);
            end
        end
    end

    assign mul_a_tvalid = issue_vld;
    assign mul_b_tvalid = issue_vld;

    // Tag delay line: its tail lines up with the multiplier output for the same operation.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) begin
                tag_vld[s]  <= 1'b0;
                tag_pipe[s] <= '0;
            end
        end else begin
            tag_vld[0]  <= issue_vld;
            tag_pipe[0] <= issue_tag;
            for (int s = 1; s < LAT; s++) begin
                tag_vld[s]  <= tag_vld[s-1];
                tag_pipe[s] <= tag_pipe[s-1];
            end
        end
    end

    assign wb_vld = tag_vld[LAT-1];
    assign wb_tag = tag_pipe[LAT-1];

    // Results arriving without a matching tag are leftovers from before reset and are dropped.
    always_comb begin
        wb_hit = '0;
        if (wb_vld) begin
            wb_hit[wb_tag] = 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                in_flight[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                case ({req_ready[i], wb_hit[i]})
                    2'b10:   in_flight[i] <= in_flight[i] + CNT_W'(1);
                    2'b01:   in_flight[i] <= in_flight[i] - CNT_W'(1);
                    default: in_flight[i] <= in_flight[i];
                endcase
            end
        end
    end

    // A tagged slot with no multiplier result means the pipelines lost alignment; keep the data anyway.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            err_sync <= 1'b0;
        end else if (wb_vld && !mul_result_tvalid) begin
            err_sync <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_res
        fmul_result_fifo #(
            .WIDTH (FLOAT_SIZE),
            .DEPTH (RES_DEPTH)
        ) u_fifo (
            .clk       (aclk),
            .rst       (rst),
            .push      (wb_hit[i]),
            .push_data (mul_result_tdata),
            .pop       (res_ready[i]),
            .head      (res_data[i*FLOAT_SIZE +: FLOAT_SIZE]),
            .count     (fifo_count[i])
        );
        assign res_valid[i] = (fifo_count[i] != '0);
    end

endmodule
